// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back sequencer: source indices,
// FSM state encoding and the default stack-pointer register.
package wb_pkg;

  localparam logic [2:0] SRC_ALU   = 3'd0;
  localparam logic [2:0] SRC_MEM   = 3'd1;
  localparam logic [2:0] SRC_HI    = 3'd2;
  localparam logic [2:0] SRC_LO    = 3'd3;
  localparam logic [2:0] SRC_SHIFT = 3'd4;
  localparam logic [2:0] SRC_LUI   = 3'd5;
  localparam logic [2:0] SRC_LT    = 3'd6;
  localparam logic [2:0] SRC_CONST = 3'd7;

  localparam int unsigned SP_REG_DEFAULT = 29;
  localparam int unsigned NUM_SRC        = 7;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_WRITE    = 2'd3
  } wb_state_e;

  // One-hot acknowledge for a granted source index.
  function automatic logic [6:0] onehot7(input logic [2:0] idx);
    logic [6:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter7.sv
// Seven-way round-robin picker: returns the first requesting source after ptr,
// wrapping 6 -> 0, so ptr itself has the lowest priority.
module rr_arbiter7 (
  input  logic [6:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] idx,
  output logic       valid
);

  logic [3:0] sum;
  logic [2:0] pos;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 7; k >= 1; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      pos = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
      if (req[pos]) begin
        idx   = pos;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: one SP init write after reset, then round-robin grants of the
// seven datapath sources onto the MemtoReg mux, with a fixed wait for memory loads.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned MEM_SRC = 1,
  parameter int unsigned SP_REG  = SP_REG_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] req,
  input  logic [34:0] req_dst,
  output logic [6:0] ack,
  output logic [2:0] mem_to_reg,
  output logic [4:0] reg_dst_addr,
  output logic       reg_write,
  output logic       busy,
  output logic       init_done,
  output wb_state_e  state
);

  localparam logic [2:0] MEM_SEL = 3'(MEM_SRC);
  localparam logic [4:0] SP_ADDR = 5'(SP_REG);
  localparam logic [3:0] LAT_M1  = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);
  localparam bit         HAS_LAT = (MEM_LAT != 0);

  // Valid/ready contract: a source raises req[i] with a stable req_dst slice and keeps
  // both until it sees ack[i]; it drops req[i] the cycle after. Anything that changes
  // after the grant is ignored and the granted write always completes.

  logic [2:0] ptr;
  logic [3:0] cnt;
  logic [2:0] idx_q;
  logic [4:0] dst_q;
  logic [2:0] arb_idx;
  logic       arb_valid;
  logic [4:0] pick_dst;

  rr_arbiter7 u_arb (
    .req   (req),
    .ptr   (ptr),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign pick_dst = req_dst[arb_idx*5 +: 5];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_INIT;
      mem_to_reg   <= SRC_CONST;
      reg_dst_addr <= '0;
      reg_write    <= 1'b0;
      ack          <= '0;
      busy         <= 1'b1;
      init_done    <= 1'b0;
      ptr          <= 3'd6;
      cnt          <= '0;
      idx_q        <= '0;
      dst_q        <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          mem_to_reg   <= SRC_CONST;
          reg_dst_addr <= SP_ADDR;
          reg_write    <= 1'b1;
          ack          <= '0;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        ST_IDLE: begin
          // The first IDLE edge follows the SP write, so init_done lands the cycle after it.
          init_done <= 1'b1;
          reg_write <= 1'b0;
          ack       <= '0;
          if (arb_valid) begin
            idx_q <= arb_idx;
            dst_q <= pick_dst;
            ptr   <= arb_idx;
            busy  <= 1'b1;
            if (HAS_LAT && (arb_idx == MEM_SEL)) begin
              mem_to_reg <= MEM_SEL;
              cnt        <= LAT_M1;
              state      <= ST_MEM_WAIT;
            end else begin
              mem_to_reg   <= arb_idx;
              reg_dst_addr <= pick_dst;
              reg_write    <= (pick_dst != 5'd0);
              ack          <= onehot7(arb_idx);
              state        <= ST_WRITE;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (cnt == 4'd0) begin
            mem_to_reg   <= idx_q;
            reg_dst_addr <= dst_q;
            reg_write    <= (dst_q != 5'd0);
            ack          <= onehot7(idx_q);
            state        <= ST_WRITE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WRITE: begin
          reg_write <= 1'b0;
          ack       <= '0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed and randomized checks of wb_sequencer against a transaction-level
// round-robin model of the write-back rules.
module tb_wb_sequencer;
  import wb_pkg::*;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned MEM_SRC = 1;
  localparam int unsigned SP_REG  = 29;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  req = '0;
  logic [34:0] req_dst = '0;
  logic [6:0]  ack;
  logic [2:0]  mem_to_reg;
  logic [4:0]  reg_dst_addr;
  logic        reg_write;
  logic        busy;
  logic        init_done;
  wb_state_e   state;

  int tests_run = 0;
  int tests_failed = 0;
  int model_last = 6;
  int obs_q[$];

  // clock / reset
  always #5 clk = ~clk;

  wb_sequencer #(.MEM_LAT(MEM_LAT), .MEM_SRC(MEM_SRC), .SP_REG(SP_REG)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_dst      (req_dst),
    .ack          (ack),
    .mem_to_reg   (mem_to_reg),
    .reg_dst_addr (reg_dst_addr),
    .reg_write    (reg_write),
    .busy         (busy),
    .init_done    (init_done),
    .state        (state)
  );

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requester after the last granted source, wrapping 6 -> 0.
  function automatic int rr_pick(input logic [6:0] r, input int last);
    for (int k = 1; k <= 7; k++) begin
      if (r[(last + k) % 7]) return (last + k) % 7;
    end
    return -1;
  endfunction

  // Serve every pending request; entered at a negedge while the DUT is in IDLE.
  task automatic service_all(input bit inject);
    int idx;
    int guard;
    logic [4:0] d;
    logic [6:0] extra;
    guard = 0;
    while (req != 0 && guard < 200) begin
      guard++;
      idx = rr_pick(req, model_last);
      d = req_dst[idx*5 +: 5];
      @(posedge clk);
      if (idx == int'(MEM_SRC)) begin
        for (int c = 0; c < int'(MEM_LAT); c++) begin
          @(negedge clk);
          chk("wait_sel", 35'(mem_to_reg), 35'(MEM_SRC));
          chk("wait_we", 35'(reg_write), 35'd0);
          chk("wait_ack", 35'(ack), 35'd0);
          chk("wait_busy", 35'(busy), 35'd1);
          @(posedge clk);
        end
      end
      @(negedge clk);
      chk("wr_ack", 35'(ack), 35'(7'd1 << idx));
      chk("wr_sel", 35'(mem_to_reg), 35'(idx));
      chk("wr_we", 35'(reg_write), 35'(d != 5'd0));
      if (d != 5'd0) chk("wr_addr", 35'(reg_dst_addr), 35'(d));
      for (int i = 0; i < 7; i++) if (ack[i]) obs_q.push_back(i);
      if (inject && $urandom_range(0, 1) == 1) begin
        extra = 7'($urandom_range(0, 127)) & ~req;
        for (int i = 0; i < 7; i++) if (extra[i]) req_dst[i*5 +: 5] = 5'($urandom_range(0, 31));
        req = req | extra;
      end
      @(posedge clk);
      #1 req[idx] = 1'b0;
      @(negedge clk);
      chk("idle_ack", 35'(ack), 35'd0);
      chk("idle_we", 35'(reg_write), 35'd0);
      chk("idle_busy", 35'(busy), 35'd0);
      chk("idle_sel_hold", 35'(mem_to_reg), 35'(idx));
      model_last = idx;
    end
    if (guard >= 200) chk("service_bound", 35'(req), 35'd0);
  endtask

  task automatic release_and_check_init();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("init_sel", 35'(mem_to_reg), 35'(3'b111));
    chk("init_addr", 35'(reg_dst_addr), 35'(SP_REG));
    chk("init_we", 35'(reg_write), 35'd1);
    chk("init_ack", 35'(ack), 35'd0);
    chk("init_done_c1", 35'(init_done), 35'd0);
    @(posedge clk);
    @(negedge clk);
    chk("init_done_c2", 35'(init_done), 35'd1);
    chk("busy_c2", 35'(busy), 35'd0);
    chk("we_c2", 35'(reg_write), 35'd0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_state", 35'(state), 35'(ST_INIT));
    chk("rst_sel", 35'(mem_to_reg), 35'(3'b111));
    chk("rst_addr", 35'(reg_dst_addr), 35'd0);
    chk("rst_we", 35'(reg_write), 35'd0);
    chk("rst_ack", 35'(ack), 35'd0);
    chk("rst_busy", 35'(busy), 35'd1);
    chk("rst_init_done", 35'(init_done), 35'd0);
    release_and_check_init();

    // single ALU write to r8
    req_dst[4:0] = 5'd8;
    req = 7'b0000001;
    service_all(1'b0);

    // memory load into r9 with MEM_LAT wait cycles
    req_dst[9:5] = 5'd9;
    req = 7'b0000010;
    service_all(1'b0);

    // park the pointer on source 6, then all seven request together
    req_dst[34:30] = 5'd20;
    req = 7'b1000000;
    service_all(1'b0);
    obs_q.delete();
    for (int i = 0; i < 7; i++) req_dst[i*5 +: 5] = 5'(i + 10);
    req = 7'b1111111;
    service_all(1'b0);
    chk("all_count", 35'(obs_q.size()), 35'd7);
    for (int i = 0; i < 7 && i < obs_q.size(); i++) chk("all_order", 35'(obs_q[i]), 35'(i));
    req = 7'b0000001;
    req_dst[4:0] = 5'd3;
    obs_q.delete();
    service_all(1'b0);
    chk("wrap_to_0", 35'(obs_q.size() > 0 ? obs_q[0] : 99), 35'd0);

    // destination $zero: ack without write enable
    req_dst[14:10] = 5'd0;
    req = 7'b0000100;
    service_all(1'b0);

    // randomized traffic with late arrivals
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 7; i++) req_dst[i*5 +: 5] = 5'($urandom_range(0, 31));
      req = 7'($urandom_range(1, 127));
      service_all(1'b1);
    end

    // reset during MEM_WAIT drops the load and re-runs the SP init
    req_dst[9:5] = 5'd9;
    req = 7'b0000010;
    @(posedge clk);
    @(negedge clk);
    chk("mw_busy", 35'(busy), 35'd1);
    chk("mw_sel", 35'(mem_to_reg), 35'(MEM_SRC));
    reset_n = 1'b0;
    #1;
    chk("mw_rst_sel", 35'(mem_to_reg), 35'(3'b111));
    chk("mw_rst_we", 35'(reg_write), 35'd0);
    chk("mw_rst_init_done", 35'(init_done), 35'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mw_rst_ack", 35'(ack), 35'd0);
    end
    req = '0;
    model_last = 6;
    release_and_check_init();
    req_dst[4:0] = 5'd5;
    req = 7'b0000001;
    service_all(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
